// File: rtl/wavetable_reader_pkg.sv
// Shared types and defaults for the wavetable oscillator slice.
// Table words are offset-binary; flipping the MSB yields two's complement.
package wavetable_pkg;

  localparam int unsigned PHASE_W_DEF = 24;
  localparam int unsigned ADDR_W_DEF  = 9;
  localparam int unsigned FRAC_W_DEF  = 8;
  localparam int unsigned DATA_W_DEF  = 16;

  localparam logic [15:0] OFFSET_BIN = 16'h8000;

  typedef enum logic [2:0] {
    IDLE,
    RD0,
    CAP0,
    RD1,
    CAP1,
    LERP
  } state_t;

endpackage

// File: rtl/wavetable_reader_if.sv
// Table RAM port bundle: the reader is master, the RAM wrapper is slave.
interface wavetable_reader_if #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 16
);

  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_ce;
  logic              ram_re;
  logic              ram_we;
  logic [DATA_W-1:0] ram_rdata;

  modport master (
    output ram_addr, ram_wdata, ram_ce, ram_re, ram_we,
    input  ram_rdata
  );

  modport slave (
    input  ram_addr, ram_wdata, ram_ce, ram_re, ram_we,
    output ram_rdata
  );

endinterface

// File: rtl/wavetable_reader_lerp.sv
// Linear interpolation y = s0 + ((s1 - s0) * frac >>> FRAC_W), purely combinational.
// The result always lies between s0 and s1, so truncation to DATA_W is exact.
module wt_lerp #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned FRAC_W = 8
) (
  input  logic signed [DATA_W-1:0] s0_i,
  input  logic signed [DATA_W-1:0] s1_i,
  input  logic        [FRAC_W-1:0] frac_i,
  output logic signed [DATA_W-1:0] y_o
);

  localparam int unsigned PROD_W = DATA_W + 1 + FRAC_W;

  logic signed [DATA_W:0]   diff;
  logic signed [PROD_W-1:0] diff_ext;
  logic signed [PROD_W-1:0] frac_ext;
  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W-1:0] s0_ext;

  always_comb begin
    diff     = {s1_i[DATA_W-1], s1_i} - {s0_i[DATA_W-1], s0_i};
    diff_ext = {{(PROD_W-DATA_W-1){diff[DATA_W]}}, diff};
    frac_ext = {{(PROD_W-FRAC_W){1'b0}}, frac_i};
    prod     = diff_ext * frac_ext;
    s0_ext   = {{(PROD_W-DATA_W){s0_i[DATA_W-1]}}, s0_i};
    y_o      = DATA_W'(s0_ext + (prod >>> FRAC_W));
  end

endmodule

// File: rtl/wavetable_reader.sv
// Phase-accumulator oscillator: per tick, fetch two adjacent table words and
// interpolate them into one signed sample.
module wavetable_reader
  import wavetable_pkg::*;
#(
  parameter int unsigned PHASE_W = PHASE_W_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned FRAC_W  = FRAC_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sample_tick_i,
  input  logic [PHASE_W-1:0] phase_inc_i,
  input  logic               note_on_i,
  wavetable_reader_if.master bus,
  output logic [DATA_W-1:0]  sample_out_o,
  output logic               sample_valid_o,
  output logic               busy_o,
  output logic               overrun_o
);

  state_t             state_q;
  logic [PHASE_W-1:0] phase_q;
  logic [PHASE_W-1:0] phase_d;
  logic               note_q;
  logic [ADDR_W-1:0]  idx_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [FRAC_W-1:0]  frac_q;
  logic [DATA_W-1:0]  s0_q;
  logic [DATA_W-1:0]  s1_q;
  logic [DATA_W-1:0]  sample_q;
  logic [DATA_W-1:0]  lerp_y;
  logic               ram_en_q;
  logic               valid_q;
  logic               overrun_q;

  // A note_on rising edge restarts the phase; a tick in the same cycle snaps 0.
  always_comb begin
    phase_d = phase_q;
    if (note_on_i && !note_q) begin
      phase_d = '0;
    end
  end

  wt_lerp #(
    .DATA_W(DATA_W),
    .FRAC_W(FRAC_W)
  ) u_lerp (
    .s0_i  (s0_q),
    .s1_i  (s1_q),
    .frac_i(frac_q),
    .y_o   (lerp_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      note_q    <= 1'b0;
      idx_q     <= '0;
      addr_q    <= '0;
      frac_q    <= '0;
      s0_q      <= '0;
      s1_q      <= '0;
      sample_q  <= '0;
      ram_en_q  <= 1'b0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      note_q  <= note_on_i;
      phase_q <= phase_d;
      valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (sample_tick_i) begin
            if (note_on_i) begin
              idx_q    <= phase_d[PHASE_W-1 -: ADDR_W];
              addr_q   <= phase_d[PHASE_W-1 -: ADDR_W];
              frac_q   <= phase_d[PHASE_W-ADDR_W-1 -: FRAC_W];
              phase_q  <= phase_d + phase_inc_i;
              ram_en_q <= 1'b1;
              state_q  <= RD0;
            end else begin
              sample_q <= '0;
              valid_q  <= 1'b1;
            end
          end
        end
        RD0: begin
          ram_en_q <= 1'b0;
          state_q  <= CAP0;
        end
        // Address stays put through CAPx: the RAM wrapper's bank mux follows it.
        CAP0: begin
          s0_q     <= bus.ram_rdata ^ DATA_W'(OFFSET_BIN);
          addr_q   <= idx_q + ADDR_W'(1);
          ram_en_q <= 1'b1;
          state_q  <= RD1;
        end
        RD1: begin
          ram_en_q <= 1'b0;
          state_q  <= CAP1;
        end
        CAP1: begin
          s1_q    <= bus.ram_rdata ^ DATA_W'(OFFSET_BIN);
          state_q <= LERP;
        end
        LERP: begin
          sample_q <= lerp_y;
          valid_q  <= 1'b1;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      if (sample_tick_i && (state_q != IDLE)) begin
        overrun_q <= 1'b1;
      end
    end
  end

  assign bus.ram_addr  = addr_q;
  assign bus.ram_ce    = ram_en_q;
  assign bus.ram_re    = ram_en_q;
  assign bus.ram_we    = 1'b0;
  assign bus.ram_wdata = '0;

  assign sample_out_o   = sample_q;
  assign sample_valid_o = valid_q;
  assign busy_o         = (state_q != IDLE);
  assign overrun_o      = overrun_q;

endmodule
